// File: rtl/pulse_evt_pkg.sv
// Shared definitions for the pulse event FIFO slice.
// Contents: default TS_W / DEPTH / DROP_W, a constant-capable clog2, and
// the default-width timestamp type evt_ts_t.
package pulse_evt_pkg;

    localparam int unsigned DEF_TS_W   = 16;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_DROP_W = 8;

    // Ceiling log2; clog2(1) = 0, clog2(8) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    typedef logic [DEF_TS_W-1:0] evt_ts_t;

endpackage

// File: rtl/pulse_event_fifo_sync_fifo.sv
// Generic single-clock FIFO (module sync_fifo).
// Ports: CLK, RST (sync, active-high), WR_EN/WR_DATA push side,
// RD_EN/RD_DATA pop side (show-ahead head data), FULL, EMPTY,
// COUNT (registered occupancy 0..DEPTH).
// A write while full is accepted only when a read frees the slot in the same cycle.
module sync_fifo
    import pulse_evt_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_TS_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WR_EN,
    input  logic [WIDTH-1:0]        WR_DATA,
    input  logic                    RD_EN,
    output logic [WIDTH-1:0]        RD_DATA,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [clog2(DEPTH):0]   COUNT
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    // Pointer MSB differs and address bits match => full.
    assign FULL    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign EMPTY   = (wr_ptr == rd_ptr);
    assign rd_ok   = RD_EN & ~EMPTY;
    assign wr_ok   = WR_EN & (~FULL | rd_ok);
    assign RD_DATA = mem[rd_ptr[AW-1:0]];

    // Storage array, no reset needed: contents are qualified by the pointers.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= WR_DATA;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (wr_ok && !rd_ok) begin
                COUNT <= COUNT + ONE;
            end else if (rd_ok && !wr_ok) begin
                COUNT <= COUNT - ONE;
            end
        end
    end

endmodule

// File: rtl/pulse_event_fifo.sv
// Timestamps single-cycle event pulses and queues them for a valid/ready consumer.
// Ports: CLK, RST (sync, active-high), SIG_I event pulse, EVT_VALID/EVT_READY/EVT_TS
// head handshake, EVT_COUNT occupancy, OVF sticky drop flag, OVF_CLR clear,
// DROP_CNT saturating drop count (only when PULSE_EVT_DROP_CNT_EN is defined).
// Build option: define PULSE_EVT_DROP_CNT_EN to add DROP_W and DROP_CNT.
module pulse_event_fifo
    import pulse_evt_pkg::*;
#(
    parameter int unsigned TS_W   = DEF_TS_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
`ifdef PULSE_EVT_DROP_CNT_EN
    ,
    parameter int unsigned DROP_W = DEF_DROP_W
`endif
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    SIG_I,
    output logic                    EVT_VALID,
    input  logic                    EVT_READY,
    output logic [TS_W-1:0]         EVT_TS,
    output logic [clog2(DEPTH):0]   EVT_COUNT,
    output logic                    OVF,
    input  logic                    OVF_CLR
`ifdef PULSE_EVT_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]       DROP_CNT
`endif
);

    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] head_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            drop;

    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign pop  = ~fifo_empty & EVT_READY;
    assign push = SIG_I & (~fifo_full | pop);
    assign drop = SIG_I & fifo_full & ~pop;

    assign EVT_VALID = ~fifo_empty;
    assign EVT_TS    = fifo_empty ? '0 : head_data;

    // Free-running timestamp; wrap is silent.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Sticky overflow; a drop in the clearing cycle wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (drop) begin
            OVF <= 1'b1;
        end else if (OVF_CLR) begin
            OVF <= 1'b0;
        end
    end

`ifdef PULSE_EVT_DROP_CNT_EN
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Saturating drop counter; a coincident clear restarts it at one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DROP_CNT <= '0;
        end else if (drop) begin
            if (OVF_CLR) begin
                DROP_CNT <= DROP_W'(1);
            end else if (DROP_CNT != DROP_MAX) begin
                DROP_CNT <= DROP_CNT + DROP_W'(1);
            end
        end else if (OVF_CLR) begin
            DROP_CNT <= '0;
        end
    end
`endif

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .WR_EN   (push),
        .WR_DATA (ts_q),
        .RD_EN   (pop),
        .RD_DATA (head_data),
        .FULL    (fifo_full),
        .EMPTY   (fifo_empty),
        .COUNT   (EVT_COUNT)
    );

endmodule

// File: tb/tb_pulse_event_fifo.sv
// Self-checking bench for pulse_event_fifo: default instance (TS_W=16, DEPTH=8)
// plus a TS_W=4 instance for timestamp wrap. Expected stamps go into queues,
// forked monitors pop and compare on every accepted head.
module tb_pulse_event_fifo;
    import pulse_evt_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic        ready;
    logic        valid;
    logic [15:0] ts;
    logic [3:0]  count;
    logic        ovf;
    logic        ovf_clr;
`ifdef PULSE_EVT_DROP_CNT_EN
    logic [7:0]  drop_cnt;
    logic [7:0]  drop_cnt4;
`endif

    logic        sig4;
    logic        ready4;
    logic        valid4;
    logic [3:0]  ts4;
    logic [3:0]  count4;
    logic        ovf4;

    logic [15:0] tb_ts;
    logic [3:0]  tb_ts4;

    evt_ts_t     exp_q[$];
    logic [3:0]  exp_q4[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Reference timestamps: same free-running behaviour as described for the DUT.
    always @(posedge clk) begin
        tb_ts  <= rst ? 16'd0 : tb_ts + 16'd1;
        tb_ts4 <= rst ? 4'd0  : tb_ts4 + 4'd1;
    end

    pulse_event_fifo #(.TS_W(16), .DEPTH(8)) dut (
        .CLK(clk), .RST(rst), .SIG_I(sig), .EVT_VALID(valid), .EVT_READY(ready),
        .EVT_TS(ts), .EVT_COUNT(count), .OVF(ovf), .OVF_CLR(ovf_clr)
`ifdef PULSE_EVT_DROP_CNT_EN
        , .DROP_CNT(drop_cnt)
`endif
    );

    pulse_event_fifo #(.TS_W(4), .DEPTH(8)) dut4 (
        .CLK(clk), .RST(rst), .SIG_I(sig4), .EVT_VALID(valid4), .EVT_READY(ready4),
        .EVT_TS(ts4), .EVT_COUNT(count4), .OVF(ovf4), .OVF_CLR(1'b0)
`ifdef PULSE_EVT_DROP_CNT_EN
        , .DROP_CNT(drop_cnt4)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input logic [15:0] t);
        for (int i = 0; i < 200 && tb_ts != t; i++) step();
        if (tb_ts != t) begin
            n_checks++;
            $display("FAIL wait_ts: timeout waiting for ts %0d", t);
        end
    endtask

    task automatic wait_ts4(input logic [3:0] t);
        for (int i = 0; i < 40 && tb_ts4 != t; i++) step();
        if (tb_ts4 != t) begin
            n_checks++;
            $display("FAIL wait_ts4: timeout waiting for ts %0d", t);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    endtask

    // Monitors: compare every accepted head against the expected queue.
    task automatic mon_main();
        evt_ts_t e;
        forever begin
            @(negedge clk);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL evt_ts: unexpected event %0d, expected none", ts);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_ts", 32'(ts), 32'(e));
                end
            end
        end
    endtask

    task automatic mon_wrap();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (valid4 && ready4) begin
                if (exp_q4.size() == 0) begin
                    n_checks++;
                    $display("FAIL evt_ts4: unexpected event %0d, expected none", ts4);
                end else begin
                    e = exp_q4.pop_front();
                    check("evt_ts4", 32'(ts4), 32'(e));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; sig = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        sig4 = 1'b0; ready4 = 1'b1;
        fork
            mon_main();
            mon_wrap();
        join_none

        // Reset state
        step(); step();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ts",    32'(ts),    32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        rst = 1'b0;

        // 1: single pulse at ts=5, consumer ready
        ready = 1'b1;
        wait_ts(16'd5);
        sig = 1'b1; exp_q.push_back(16'd5);
        step();
        sig = 1'b0;
        check("t1_valid", 32'(valid), 32'd1);
        step();
        check("t1_count", 32'(count), 32'd0);
        check("t1_ovf",   32'(ovf),   32'd0);

        // 2: ten-cycle burst at ts=20 into a stalled consumer
        ready = 1'b0;
        wait_ts(16'd20);
        for (int i = 0; i < 10; i++) begin
            sig = 1'b1;
            if (i < 8) exp_q.push_back(16'(20 + i));
            step();
        end
        sig = 1'b0;
        check("t2_count", 32'(count), 32'd8);
        check("t2_ovf",   32'(ovf),   32'd1);
        check("t2_head",  32'(ts),    32'd20);
`ifdef PULSE_EVT_DROP_CNT_EN
        check("t2_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // 3: full with simultaneous pop and push at ts=30
        ready = 1'b1; sig = 1'b1; exp_q.push_back(16'd30);
        step();
        sig = 1'b0; ready = 1'b0;
        check("t3_count", 32'(count), 32'd8);
        check("t3_ovf",   32'(ovf),   32'd1);
`ifdef PULSE_EVT_DROP_CNT_EN
        check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
        ready = 1'b1;
        drain();
        ready = 1'b0;
        check("t3_drained", 32'(count), 32'd0);
        check("t3_valid",   32'(valid), 32'd0);

        // 5: clear alone, then clear coinciding with a drop
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t5_clr_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            sig = 1'b1; exp_q.push_back(tb_ts);
            step();
        end
        ovf_clr = 1'b1;
        step();
        sig = 1'b0; ovf_clr = 1'b0;
        check("t5_set_wins", 32'(ovf),   32'd1);
        check("t5_count",    32'(count), 32'd8);
`ifdef PULSE_EVT_DROP_CNT_EN
        check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t5_clr_later", 32'(ovf), 32'd0);
`ifdef PULSE_EVT_DROP_CNT_EN
        check("t5_drop_clr", 32'(drop_cnt), 32'd0);
`endif

        // 6: reset with three entries queued
        ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ready = 1'b0;
        check("t6_count3", 32'(count), 32'd3);
        rst = 1'b1;
        exp_q.delete();
        exp_q4.delete();
        step();
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_ts",    32'(ts),    32'd0);
        rst = 1'b0;
        sig = 1'b1; ready = 1'b1; exp_q.push_back(16'd0);
        step();
        sig = 1'b0;
        drain();
        check("t6_drained", 32'(count), 32'd0);

        // 4: TS_W=4 wrap, pulses at 14 and then at 1
        wait_ts4(4'd14);
        sig4 = 1'b1; exp_q4.push_back(4'd14);
        step();
        sig4 = 1'b0;
        wait_ts4(4'd1);
        sig4 = 1'b1; exp_q4.push_back(4'd1);
        step();
        sig4 = 1'b0;
        step(); step();
        check("t4_count", 32'(count4), 32'd0);

        check("q_main_empty", 32'(exp_q.size()),  32'd0);
        check("q_wrap_empty", 32'(exp_q4.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
